// File: rtl/rom_arb_pkg.sv
// Shared constants for the ROM read arbiter: widths, ROM depth and contents.
package rom_arb_pkg;

    localparam int ADDR_W    = 3;
    localparam int DATA_W    = 4;
    localparam int ROM_DEPTH = 8;
    localparam int ROM_W     = 4;

    // Word i lives at bits [i*ROM_W +: ROM_W]; addresses 0..7 hold 1,2,3,4,8,A,C,F.
    localparam logic [ROM_DEPTH*ROM_W-1:0] ROM_INIT = 32'hFCA8_4321;

    function automatic logic [ROM_W-1:0] rom_lookup(input logic [ADDR_W-1:0] addr);
        return ROM_INIT[int'(addr)*ROM_W +: ROM_W];
    endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester and response handshake bundle for the ROM read arbiter.
interface rom_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 3,
    parameter int DATA_W  = 4,
    parameter int ID_W    = 1
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic [ID_W-1:0]           rsp_id;

    // Client side: issues requests, consumes responses.
    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/rom_8x4.sv
// Combinational 8-entry, 4-bit constant ROM.
module rom_8x4
    import rom_arb_pkg::*;
(
    input  logic [ADDR_W-1:0] addr_i,
    output logic [ROM_W-1:0]  data_o
);
    assign data_o = rom_lookup(addr_i);
endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester after last_grant, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_grant_i,
    input  logic               enable_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o,
    output logic               any_o
);
    // Priority search starting one past the previous winner.
    always_comb begin
        int          c;
        logic [ID_W-1:0] cand;
        logic        found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        c       = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            c    = (int'(last_grant_i) + k) % NUM_REQ;
            cand = ID_W'(c);
            if (enable_i && !found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                found         = 1'b1;
            end
        end
    end

    assign any_o = |grant_o;
endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one 8x4 ROM among NUM_REQ requesters through a one-entry response slot.
module rom_read_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic               clk,
    input  logic               rst,
    rom_read_arbiter_if.slave  bus
);
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_idx;
    logic               gnt_any;
    logic               can_accept;
    logic [ADDR_W-1:0]  rom_addr;
    logic [ROM_W-1:0]   rom_data;

    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q,  rsp_data_d;
    logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;

    // Slot can take a new word when empty or being drained this cycle.
    assign can_accept = !rsp_valid_q || bus.rsp_ready;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .enable_i     (can_accept),
        .grant_o      (grant),
        .idx_o        (gnt_idx),
        .any_o        (gnt_any)
    );

    // Address mux driven by the one-hot grant.
    always_comb begin
        rom_addr = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) rom_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
    end

    rom_8x4 u_rom (
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Slot next state: load on grant, else clear when drained.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_id_d     = rsp_id_q;
        last_grant_d = last_grant_q;
        if (gnt_any) begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = DATA_W'(rom_data);
            rsp_id_d     = gnt_idx;
            last_grant_d = gnt_idx;
        end else if (bus.rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    // State registers; pointer resets so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
            rsp_id_q     <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            rsp_id_q     <= rsp_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with hand-computed expectations.
module tb_rom_read_arbiter;
    import rom_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    localparam logic [3:0] SWEEP [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'hA, 4'hC, 4'hF};

    rom_read_arbiter_if #(.NUM_REQ(2), .ADDR_W(3), .DATA_W(4), .ID_W(1)) bus ();

    rom_read_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input logic [2:0] a0, input logic [2:0] a1);
        bus.req_addr = {a1, a0};
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        set_addr(3'd0, 3'd0);
        step();
        step();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 4'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL reset_id got=%b exp=0", bus.rsp_id); end
        rst = 1'b0;
        bus.req_valid = 2'b01;
        set_addr(3'd3, 3'd0);
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_ready got=%b exp=01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        #1;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 4'b0100) begin errors++; $display("FAIL single_data got=%h exp=4", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL single_id got=%b exp=0", bus.rsp_id); end
        step();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [0:0] exp_id [4];
        logic [3:0] exp_d  [4];
        exp_id = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_d  = '{4'hF, 4'h8, 4'hF, 4'h8};
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        set_addr(3'd7, 3'd4);
        bus.req_valid = 2'b11;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rr_first_ready got=%b exp=01", bus.req_ready); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got=%b exp=1", k, bus.rsp_valid); end
            checks++; if (bus.rsp_id !== exp_id[k]) begin errors++; $display("FAIL rr_id[%0d] got=%b exp=%b", k, bus.rsp_id, exp_id[k]); end
            checks++; if (bus.rsp_data !== exp_d[k]) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", k, bus.rsp_data, exp_d[k]); end
        end
        bus.req_valid = 2'b00;
        step();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got=%b exp=0", bus.rsp_valid); end
    endtask

    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        set_addr(3'd2, 3'd5);
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=00", k, bus.req_ready); end
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%b exp=1", k, bus.rsp_valid); end
            checks++; if (bus.rsp_data !== 4'hA) begin errors++; $display("FAIL bp_data[%0d] got=%h exp=a", k, bus.rsp_data); end
            checks++; if (bus.rsp_id !== 1'b1) begin errors++; $display("FAIL bp_id[%0d] got=%b exp=1", k, bus.rsp_id); end
            step();
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_release_ready got=%b exp=01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        #1;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid got=%b exp=1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 4'h3) begin errors++; $display("FAIL bp_release_data got=%h exp=3", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL bp_release_id got=%b exp=0", bus.rsp_id); end
        step();
    endtask

    task automatic test_idle_priority();
        bus.rsp_ready = 1'b1;
        set_addr(3'd6, 3'd0);
        bus.req_valid = 2'b10;
        step();
        bus.req_valid = 2'b00;
        checks++; if (bus.rsp_id !== 1'b1) begin errors++; $display("FAIL idle_setup_id got=%b exp=1", bus.rsp_id); end
        step();
        step();
        step();
        set_addr(3'd6, 3'd1);
        bus.req_valid = 2'b11;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL idle_ready got=%b exp=01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL idle_id got=%b exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 4'hC) begin errors++; $display("FAIL idle_data got=%h exp=c", bus.rsp_data); end
        step();
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready = 1'b0;
        set_addr(3'd4, 3'd0);
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_pending got=%b exp=1", bus.rsp_valid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 4'h0) begin errors++; $display("FAIL mid_data got=%h exp=0", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL mid_id got=%b exp=0", bus.rsp_id); end
        bus.rsp_ready = 1'b1;
        set_addr(3'd1, 3'd2);
        bus.req_valid = 2'b11;
        #1;
        checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL mid_ready got=%b exp=01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        checks++; if (bus.rsp_id !== 1'b0) begin errors++; $display("FAIL mid_grant_id got=%b exp=0", bus.rsp_id); end
        checks++; if (bus.rsp_data !== 4'h2) begin errors++; $display("FAIL mid_grant_data got=%h exp=2", bus.rsp_data); end
        step();
    endtask

    task automatic test_sweep();
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b01;
        for (int i = 0; i < 8; i++) begin
            set_addr(3'(i), 3'd0);
            step();
            checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid[%0d] got=%b exp=1", i, bus.rsp_valid); end
            checks++; if (bus.rsp_data !== SWEEP[i]) begin errors++; $display("FAIL sweep_data[%0d] got=%h exp=%h", i, bus.rsp_data, SWEEP[i]); end
            checks++; if (bus.rsp_data !== rom_lookup(3'(i))) begin errors++; $display("FAIL sweep_pkg[%0d] got=%h exp=%h", i, bus.rsp_data, rom_lookup(3'(i))); end
        end
        bus.req_valid = 2'b00;
        step();
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain got=%b exp=0", bus.rsp_valid); end
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_addr  = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_idle_priority();
        test_reset_mid();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rom_read_arbiter.md
Name: rom_read_arbiter

Overview:
Shares a single 8x4 ROM between NUM_REQ requesters. Each requester has a valid/ready address port. A round-robin arbiter grants one request per cycle, looks it up in the ROM, and registers the result into a one-entry response slot tagged with the requester ID. It sits between the ROM and the client blocks that read its constants, and presents a single downstream response stream with valid/ready backpressure.

Parameters:
NUM_REQ, 2, number of requester ports (2..8)
ADDR_W, 3, ROM address width (fixed to ROM depth 8)
DATA_W, 4, ROM data width
ID_W, 1, requester ID width; must equal ceil(log2(NUM_REQ)), minimum 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W]
req_ready  output  NUM_REQ  one-hot grant / accept; at most one bit high
rsp_valid  output  1  response slot holds data
rsp_ready  input  1  downstream accepts response
rsp_data  output  DATA_W  ROM word for the granted address
rsp_id  output  ID_W  index of the requester that issued the response

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst high at a clk edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has top priority first.
  - rst mid-transfer discards any held response; nothing is replayed.
- Slot state is implicit (EMPTY when rsp_valid=0, FULL when rsp_valid=1).
  - can_accept = !rsp_valid | rsp_ready.
- Arbitration is combinational.
  - When can_accept is high, grant the first requester with req_valid high, searching from last_grant+1 with wrap modulo NUM_REQ.
  - req_ready[g]=1 only for the granted g; all others 0.
  - When can_accept is low, req_ready=0 for all requesters.
  - req_ready must not depend on the requester's own req_valid beyond the priority search (no combinational loop through rsp_ready into req_valid is allowed).
- Transfer occurs when req_valid[g] & req_ready[g] are both high at a clk edge. At that edge:
  - rsp_data <= ROM[req_addr[g]].
  - rsp_id <= g.
  - rsp_valid <= 1.
  - last_grant <= g.
- Latency: response is visible 1 cycle after acceptance.
- Throughput: 1 response per cycle when rsp_ready is held high (back-to-back, no bubble).
- Response drain:
  - rsp_valid & rsp_ready with no new grant: rsp_valid <= 0 next edge.
  - Drain and new grant in the same cycle: the slot is overwritten with the new response and rsp_valid stays 1.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_data and rsp_id hold stable and no requester is granted.
- The pointer is updated only on an actual transfer. Idle cycles leave priority unchanged.
- Fairness: with all requesters continuously valid and rsp_ready=1, grants rotate 0,1,...,NUM_REQ-1,0,...
- A requester may change req_addr while not granted. The address is sampled only on its transfer edge.
- Data width: ROM output is zero-extended if DATA_W>4. DATA_W<4 is illegal.

Decomposition:
- Shared package rom_arb_pkg: ADDR_W/DATA_W constants, the ROM depth (8), and the ROM contents constant for the bench's reference model.
- Sub-modules:
  - Instantiate the existing combinational rom_8x4 once, with its address driven from the granted requester's mux.
  - One natural sub-module, rr_arbiter: parameterised NUM_REQ, inputs req, last_grant and enable; outputs a one-hot grant plus encoded index. It is reusable elsewhere.

Test Plan:
- Reset, single request:
  - Stimulus: assert rst for 2 cycles, then req_valid=01 with addr0=3, rsp_ready=1.
  - Required: req_ready=01 in that cycle; next cycle rsp_valid=1, rsp_data=4'b0100, rsp_id=0; the following cycle rsp_valid=0.
- Round-robin contention:
  - Stimulus: both requesters continuously valid (addr0=7, addr1=4), rsp_ready=1.
  - Required: rsp_id sequence is 0,1,0,1; rsp_data sequence is F,8,F,8; one response per cycle.
- Backpressure:
  - Stimulus: hold rsp_ready=0 with a response pending (addr1=5, rsp_data=A); requester 0 is valid.
  - Required: req_ready=00, and rsp_data=A / rsp_id=1 stay stable for 5 cycles. Raise rsp_ready: the requester-0 grant occurs in the same cycle and the slot updates next cycle with no bubble.
- Idle priority retention:
  - Stimulus: grant requester 1, idle 3 cycles, then both valid.
  - Required: requester 0 wins (pointer unchanged by idle cycles).
- Reset mid-operation:
  - Stimulus: assert rst while rsp_valid=1 and rsp_ready=0.
  - Required: next cycle rsp_valid=0, rsp_data=0, rsp_id=0; the next contention grants requester 0 first.
- Full address sweep:
  - Stimulus: requester 0 issues addresses 0..7 back-to-back.
  - Required: rsp_data is 1,2,3,4,8,A,C,F in order, checked against the package reference table.
